// File: rtl/instr_loader.sv
// instr_loader: packs received UART bytes big-endian into 32-bit words and writes them to instruction memory.
// Optional macro INSTR_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte check after the halt word.
`timescale 1ns/1ps
module instr_loader #(
    parameter int unsigned BITS_SIZE  = 32,
    parameter int unsigned SIZE_TOTAL = 256,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [7:0]           i_rx_data,
    input  logic                 i_rx_done,
    output logic [BITS_SIZE-1:0] o_instruction_address,
    output logic [BITS_SIZE-1:0] o_instruction,
    output logic                 o_flag_write_intruc,
    output logic                 o_loading,
    output logic                 o_load_done,
    output logic                 o_error
);

    localparam int unsigned   SHIFT_W   = 24;
    localparam int unsigned   CNT_W     = 2;
    localparam logic [BITS_SIZE-1:0] ADDR_END  = BITS_SIZE'(SIZE_TOTAL);
    localparam logic [BITS_SIZE-1:0] ADDR_STEP = BITS_SIZE'(4);
    localparam logic [BITS_SIZE-1:0] HALT_CMP  = BITS_SIZE'(HALT_WORD);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BYTE  = 3'd1,
        S_WRITE = 3'd2,
`ifdef INSTR_LOADER_CHECKSUM_EN
        S_CHECK = 3'd3,
`endif
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic [BITS_SIZE-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [BITS_SIZE-1:0] instr_q, instr_d;
    logic                 wr_q, wr_d;
    logic                 loading_q, loading_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [31:0]          packed_w;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]           xor_q, xor_d;
`endif

    // Next-state and datapath; a byte arriving during WRITE starts the next word.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        instr_d   = instr_q;
        wr_d      = 1'b0;
        done_d    = done_q;
        err_d     = err_q;
        packed_w  = {shift_q, i_rx_data};
`ifdef INSTR_LOADER_CHECKSUM_EN
        xor_d     = xor_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start) begin
                    state_d = S_BYTE;
                    addr_d  = '0;
                    cnt_d   = '0;
                    shift_d = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    xor_d   = '0;
`endif
                end
            end
            S_BYTE: begin
                if (i_rx_done) begin
                    shift_d = packed_w[SHIFT_W-1:0];
                    cnt_d   = cnt_q + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    xor_d   = xor_q ^ i_rx_data;
`endif
                    if (cnt_q == 2'd3) begin
                        if (addr_q == ADDR_END) begin
                            state_d = S_ERROR;
                            err_d   = 1'b1;
                        end else begin
                            state_d = S_WRITE;
                            wr_d    = 1'b1;
                            instr_d = BITS_SIZE'(packed_w);
                        end
                    end
                end
            end
            S_WRITE: begin
                addr_d = addr_q + ADDR_STEP;
                if (instr_q == HALT_CMP) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    // A byte landing in this cycle is already the checksum byte.
                    if (i_rx_done) begin
                        if (i_rx_data == xor_q) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_ERROR;
                            err_d   = 1'b1;
                        end
                    end else begin
                        state_d = S_CHECK;
                    end
`else
                    state_d = S_DONE;
                    done_d  = 1'b1;
`endif
                end else begin
                    state_d = S_BYTE;
                    if (i_rx_done) begin
                        shift_d = packed_w[SHIFT_W-1:0];
                        cnt_d   = cnt_q + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        xor_d   = xor_q ^ i_rx_data;
`endif
                    end
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (i_rx_done) begin
                    if (i_rx_data == xor_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
        loading_d = (state_d == S_BYTE) || (state_d == S_WRITE);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            shift_q   <= '0;
            instr_q   <= '0;
            wr_q      <= 1'b0;
            loading_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            xor_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            instr_q   <= instr_d;
            wr_q      <= wr_d;
            loading_q <= loading_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
            xor_q     <= xor_d;
`endif
        end
    end

    // addr_q only advances at the end of WRITE, so it is the write address while the strobe is high.
    assign o_instruction_address = addr_q;
    assign o_instruction         = instr_q;
    assign o_flag_write_intruc   = wr_q;
    assign o_loading             = loading_q;
    assign o_load_done           = done_q;
    assign o_error               = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: random byte programs checked against a word-level model of the expected memory writes.
`timescale 1ns/1ps
module tb_instr_loader;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam int          MEM_WORDS = 64;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        wr;
    logic        loading;
    logic        done;
    logic        err;

    int total;
    int bad;

    logic [7:0]  stream[$];
    logic [31:0] wq_a[$];
    logic [31:0] wq_d[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];
    logic        exp_done;
    logic        exp_err;
    logic        exp_loading;

    instr_loader dut (
        .i_clk                 (clk),
        .i_reset               (rst_n),
        .i_start               (start),
        .i_rx_data             (rx_data),
        .i_rx_done             (rx_done),
        .o_instruction_address (addr),
        .o_instruction         (instr),
        .o_flag_write_intruc   (wr),
        .o_loading             (loading),
        .o_load_done           (done),
        .o_error               (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every memory write seen on the port.
    always @(negedge clk) begin
        if (rst_n && wr) begin
            wq_a.push_back(addr);
            wq_d.push_back(instr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom();
        if (w == HALT) w = 32'h0;
        return w;
    endfunction

    task automatic push_word(input logic [31:0] w);
        stream.push_back(w[31:24]);
        stream.push_back(w[23:16]);
        stream.push_back(w[15:8]);
        stream.push_back(w[7:0]);
    endtask

    // Halt word plus, when checksumming, a trailing byte that is randomly right or wrong.
    task automatic end_program();
`ifdef INSTR_LOADER_CHECKSUM_EN
        logic [7:0] x;
`endif
        push_word(HALT);
`ifdef INSTR_LOADER_CHECKSUM_EN
        x = 8'h00;
        foreach (stream[i]) x = x ^ stream[i];
        stream.push_back(($urandom_range(1, 0) == 0) ? x : (x ^ 8'h5A));
`endif
    endtask

    // Expected writes and final flags, computed word by word from the byte stream.
    task automatic model();
        int         n;
        logic [31:0] w;
        logic [7:0]  x;
        logic        halted;
        exp_a.delete();
        exp_d.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        halted   = 1'b0;
        x        = 8'h00;
        n        = stream.size();
        for (int k = 0; 4 * k + 3 < n; k++) begin
            w = {stream[4*k], stream[4*k+1], stream[4*k+2], stream[4*k+3]};
            x = x ^ stream[4*k] ^ stream[4*k+1] ^ stream[4*k+2] ^ stream[4*k+3];
            if (k >= MEM_WORDS) begin
                exp_err = 1'b1;
                break;
            end
            exp_a.push_back(32'(4 * k));
            exp_d.push_back(w);
            if (w == HALT) begin
                halted = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                if (n > 4 * k + 4) begin
                    if (stream[4*k+4] == x) exp_done = 1'b1;
                    else                    exp_err  = 1'b1;
                end
`else
                exp_done = 1'b1;
`endif
                break;
            end
        end
        exp_loading = !exp_done && !exp_err && !halted;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start   = 1'b1;
        rx_done = 1'b0;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(negedge clk);
            rx_done = 1'b0;
        end
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_done = 1'b0;
        end
    endtask

    task automatic feed(input int from, input int upto, input int gapmax);
        for (int i = from; i < upto; i++)
            send_byte(stream[i], int'($urandom_range(gapmax, 0)));
    endtask

    task automatic begin_prog();
        idle(1);
        wq_a.delete();
        wq_d.delete();
        pulse_start();
        chk("arm_done", 32'(done), 32'(0));
        chk("arm_error", 32'(err), 32'(0));
        chk("arm_loading", 32'(loading), 32'(1));
    endtask

    task automatic finish_prog();
        idle(6);
        model();
        chk("n_writes", 32'(wq_a.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < wq_a.size(); i++) begin
            chk("wr_addr", wq_a[i], exp_a[i]);
            chk("wr_data", wq_d[i], exp_d[i]);
        end
        chk("load_done", 32'(done), 32'(exp_done));
        chk("error", 32'(err), 32'(exp_err));
        chk("loading", 32'(loading), 32'(exp_loading));
    endtask

    task automatic run_stream(input int gapmax);
        begin_prog();
        feed(0, stream.size(), gapmax);
        finish_prog();
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
        total   = 0;
        bad     = 0;

        repeat (3) @(negedge clk);
        chk("rst_addr", addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_wr", 32'(wr), 32'(0));
        chk("rst_loading", 32'(loading), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_error", 32'(err), 32'(0));
        rst_n = 1'b1;

        // Basic load with write-latency and single-cycle strobe checks.
        stream.delete();
        push_word(32'h2008_0005);
        push_word(HALT);
`ifdef INSTR_LOADER_CHECKSUM_EN
        stream.push_back(8'h2D);
`endif
        begin_prog();
        feed(0, 4, 1);
        idle(1);
        chk("lat_wr", 32'(wr), 32'(1));
        chk("lat_addr", addr, 32'h0);
        chk("lat_instr", instr, 32'h2008_0005);
        idle(1);
        chk("wr_one_cycle", 32'(wr), 32'(0));
        feed(4, 8, 1);
`ifndef INSTR_LOADER_CHECKSUM_EN
        idle(1);
        chk("halt_wr", 32'(wr), 32'(1));
        chk("done_not_yet", 32'(done), 32'(0));
        idle(1);
        chk("done_lat", 32'(done), 32'(1));
`endif
        feed(8, stream.size(), 1);
        finish_prog();

        // Back-to-back bytes; re-arm out of DONE.
        stream.delete();
        push_word(rand_word());
        end_program();
        run_stream(0);

        // Overflow: 65 non-halt words.
        stream.delete();
        for (int i = 0; i < MEM_WORDS + 1; i++) push_word(rand_word());
        run_stream(1);

        // Halt word in the last legal slot.
        stream.delete();
        for (int i = 0; i < MEM_WORDS - 1; i++) push_word(rand_word());
        end_program();
        run_stream(0);

        // Reset mid-load, stray bytes while idle, then a fresh program.
        stream.delete();
        push_word(rand_word());
        end_program();
        begin_prog();
        feed(0, 2, 0);
        @(negedge clk);
        rx_done = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("mid_rst_loading", 32'(loading), 32'(0));
        chk("mid_rst_addr", addr, 32'h0);
        chk("mid_rst_wr", 32'(wr), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'hA5, 0);
        send_byte(8'h5A, 0);
        idle(2);
        chk("idle_ignores_rx", 32'(loading), 32'(0));
        stream.delete();
        for (int i = 0; i < 3; i++) push_word(rand_word());
        end_program();
        run_stream(2);

        // Start pulse during BYTE is ignored.
        stream.delete();
        push_word(rand_word());
        end_program();
        begin_prog();
        feed(0, 2, 1);
        pulse_start();
        feed(2, stream.size(), 1);
        finish_prog();

`ifdef INSTR_LOADER_CHECKSUM_EN
        stream.delete();
        push_word(32'h0000_0001);
        push_word(HALT);
        stream.push_back(8'h01);
        run_stream(1);
        chk("ck_good_done", 32'(done), 32'(1));
        stream[8] = 8'h02;
        run_stream(1);
        chk("ck_bad_error", 32'(err), 32'(1));
`endif

        // Random programs with random byte spacing.
        for (int t = 0; t < 15; t++) begin
            stream.delete();
            for (int i = 0; i < int'($urandom_range(8, 0)); i++) push_word(rand_word());
            end_program();
            run_stream(int'($urandom_range(2, 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Writer-side loader for the instruction memory. Collects a byte stream from the debug UART receiver and packs every 4 bytes into a 32-bit instruction word. Each word is written to consecutive word-aligned addresses through the instruction-memory write port (`instruction address`, `instruction`, `flag_write_intruc`). Runs while the pipeline is stalled, before stepping begins. Signals completion to the debug controller when it sees the halt word.

## Interface
- `BITS_SIZE`, 32: address and instruction width.
- `SIZE_TOTAL`, 256: instruction memory size in bytes (64 words).
- `HALT_WORD`, 32'hFFFF_FFFF: end-of-program marker.
- `i_clk`, in, 1: single clock, rising edge.
- `i_reset`, in, 1: reset, asynchronous and active-low.
- `i_start`, in, 1: arm the loader; one-cycle pulse.
- `i_rx_data`, in, 8: received byte.
- `i_rx_done`, in, 1: one-cycle strobe; `i_rx_data` is valid this cycle.
- `o_instruction_address`, out, `BITS_SIZE`: byte address of the word being written.
- `o_instruction`, out, `BITS_SIZE`: assembled word.
- `o_flag_write_intruc`, out, 1: one-cycle write strobe to instruction memory.
- `o_loading`, out, 1: high in the BYTE and WRITE states.
- `o_load_done`, out, 1: level; halt word written (and checksum passed when enabled).
- `o_error`, out, 1: level; overflow or checksum mismatch.

## Operation
- **States:** IDLE, BYTE, WRITE, CHECK (only when the macro is defined), DONE, ERROR.
- **IDLE:**
  - `i_rx_done` is ignored.
  - `i_start` goes to BYTE and clears the address, byte count, shift register and checksum.
- **BYTE:**
  - On each `i_rx_done`: `shift <= {shift[23:0], i_rx_data}`. The first byte ends up as the MSB (big-endian).
  - Byte count is 2 bits; when it wraps from 3 to 0, go to WRITE.
- **WRITE** lasts one cycle:
  - `o_flag_write_intruc=1`, with `o_instruction` = the packed word and `o_instruction_address` = the current address.
  - The next cycle the address increments by 4.
  - If the word equals `HALT_WORD`, go to DONE (or CHECK when enabled). Otherwise go back to BYTE.
  - An `i_rx_done` arriving during WRITE is captured as byte 0 of the next word. No byte is dropped.
- **Overflow:**
  - A word completing when the address equals `SIZE_TOTAL` is not written.
  - The loader goes to ERROR with `o_error=1`.
  - A halt word placed in the last slot (address `SIZE_TOTAL-4`) is legal.
- **DONE / ERROR:**
  - Both hold their output flag.
  - `i_start` re-arms the loader (same effect as from IDLE) and clears `o_load_done` and `o_error`.
- `i_start` while in BYTE, WRITE or CHECK is ignored.
- Address arithmetic is `BITS_SIZE` wide and unsigned. Bits [1:0] are always 0.

## Timing
- **Reset:** all outputs are 0 and the state is IDLE. Reset mid-load aborts immediately; memory contents already written are left as-is.
- **Write latency:** `o_flag_write_intruc` is asserted in the cycle after the `i_rx_done` carrying the 4th byte.
- `o_instruction` and `o_instruction_address` are registered and stable while the strobe is high.
- `o_load_done` / `o_error` rise in the cycle after the final WRITE (or CHECK byte).
- Minimum byte spacing is 1 cycle (back-to-back strobes are supported).

## Configuration
- **`INSTR_LOADER_CHECKSUM_EN` defined:**
  - A running XOR accumulates every received byte, including the halt word's bytes.
  - After the halt-word write, the state goes to CHECK and the next received byte is compared with the accumulated XOR.
  - Match goes to DONE. Mismatch goes to ERROR.
- **Not defined:** the CHECK state and the XOR register are absent, and the halt-word write goes directly to DONE.

## Test plan
- **Basic load:** reset, `i_start`, then bytes 20,08,00,05, FF,FF,FF,FF.
  - Write 0x20080005 at address 0, then 0xFFFFFFFF at address 4.
  - `o_load_done=1`, `o_error=0`.
- **Back-to-back bytes:** `i_rx_done` asserted every cycle for 8 bytes.
  - Exactly 2 strobes, correct words, no dropped byte during WRITE.
- **Overflow:** 65 non-halt words.
  - 64 strobes (addresses 0..252).
  - On completion of the 65th word there is no strobe and `o_error=1`.
- **Reset mid-load:** assert `i_reset` low after 2 bytes of word 1, release, `i_start`, then send a full program.
  - First write is at address 0 with a fresh word.
- **Checksum (macro on):** program 00000001 + halt.
  - Checksum byte 0x01 gives DONE. Checksum byte 0x02 gives `o_error=1`.
- **Re-arm:** `i_start` in DONE, then load a new program.
  - `o_load_done` is cleared and writes restart at address 0.
